// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/funct constants, ALU/size codes and the control-bundle type
// for the MIPS main decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef struct packed {
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] store_control;
    logic       extend;
    logic       lui_control;
    logic [1:0] load_control;
    logic       regdest;
    logic       branch;
    logic       alusrc;
    logic [1:0] aluop;
    logic       jump;
    logic       jal;
    logic       jr;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '{
    memread: 1'b0, memtoreg: 1'b0, memwrite: 1'b0, regwrite: 1'b0,
    store_control: SIZE_WORD, extend: 1'b0, lui_control: 1'b0,
    load_control: SIZE_WORD, regdest: 1'b0, branch: 1'b0, alusrc: 1'b0,
    aluop: ALUOP_ADD, jump: 1'b0, jal: 1'b0, jr: 1'b0
  };

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode/funct -> control-bundle decoder.
// With CU_ILLEGAL_OP_EN defined it also flags undefined opcodes.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
`ifdef CU_ILLEGAL_OP_EN
  output logic         illegal_op,
`endif
  output ctrl_bundle_t ctrl
);

  logic illegal_s;

  // Main decode table; anything not matched falls through to the all-zero NOP
  always_comb begin
    ctrl      = CTRL_NOP;
    illegal_s = 1'b0;
    case (opcode)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.extend   = (opcode == OP_LW) || (opcode == OP_LH) || (opcode == OP_LB);
        case (opcode)
          OP_LH, OP_LHU: ctrl.load_control = SIZE_HALF;
          OP_LB, OP_LBU: ctrl.load_control = SIZE_BYTE;
          default:       ctrl.load_control = SIZE_WORD;
        endcase
      end
      OP_SW, OP_SH, OP_SB: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.extend   = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
        case (opcode)
          OP_SH:   ctrl.store_control = SIZE_HALF;
          OP_SB:   ctrl.store_control = SIZE_BYTE;
          default: ctrl.store_control = SIZE_WORD;
        endcase
      end
      OP_LUI: begin
        ctrl.regwrite    = 1'b1;
        ctrl.alusrc      = 1'b1;
        ctrl.lui_control = 1'b1;
        ctrl.aluop       = ALUOP_ADD;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.extend   = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.extend = 1'b1;
        ctrl.aluop  = ALUOP_SUB;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_RTYPE: begin
        ctrl.aluop = ALUOP_FUNCT;
        // jr must not write the regfile even though it is an R-type
        if (funct == FUNCT_JR) begin
          ctrl.jr = 1'b1;
        end else begin
          ctrl.regwrite = 1'b1;
          ctrl.regdest  = 1'b1;
        end
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

`ifdef CU_ILLEGAL_OP_EN
  assign illegal_op = illegal_s;
`else
  logic unused_s;
  assign unused_s = illegal_s;
`endif

endmodule

// File: rtl/control_unit.sv
// MIPS main control unit: registered decode of opcode/funct with async reset
// and stall hold. Optional illegal_op output under CU_ILLEGAL_OP_EN.
module control_unit
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       memread,
  output logic       memtoreg,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] store_control,
  output logic       extend,
  output logic       lui_control,
  output logic [1:0] load_control,
  output logic       regdest,
  output logic       branch,
  output logic       alusrc,
  output logic [1:0] aluop,
  output logic       jumpControl,
  output logic       jalControl,
`ifdef CU_ILLEGAL_OP_EN
  output logic       illegal_op,
`endif
  output logic       jrControl
);

  ctrl_bundle_t dec_s;
  ctrl_bundle_t ctrl_d, ctrl_q;

`ifdef CU_ILLEGAL_OP_EN
  logic dec_illegal_s;
  logic illegal_d, illegal_q;
`endif

  ctrl_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
`ifdef CU_ILLEGAL_OP_EN
    .illegal_op (dec_illegal_s),
`endif
    .ctrl       (dec_s)
  );

  // Next-state: load fresh decode unless stalled
  always_comb begin
    ctrl_d = ctrl_q;
`ifdef CU_ILLEGAL_OP_EN
    illegal_d = illegal_q;
`endif
    if (stall) begin
      ctrl_d = ctrl_q;
`ifdef CU_ILLEGAL_OP_EN
      illegal_d = illegal_q;
`endif
    end else begin
      ctrl_d = dec_s;
`ifdef CU_ILLEGAL_OP_EN
      illegal_d = dec_illegal_s;
`endif
    end
  end

  // Output bundle register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= CTRL_NOP;
`ifdef CU_ILLEGAL_OP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      ctrl_q <= ctrl_d;
`ifdef CU_ILLEGAL_OP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign memread       = ctrl_q.memread;
  assign memtoreg      = ctrl_q.memtoreg;
  assign memwrite      = ctrl_q.memwrite;
  assign regwrite      = ctrl_q.regwrite;
  assign store_control = ctrl_q.store_control;
  assign extend        = ctrl_q.extend;
  assign lui_control   = ctrl_q.lui_control;
  assign load_control  = ctrl_q.load_control;
  assign regdest       = ctrl_q.regdest;
  assign branch        = ctrl_q.branch;
  assign alusrc        = ctrl_q.alusrc;
  assign aluop         = ctrl_q.aluop;
  assign jumpControl   = ctrl_q.jump;
  assign jalControl    = ctrl_q.jal;
  assign jrControl     = ctrl_q.jr;
`ifdef CU_ILLEGAL_OP_EN
  assign illegal_op    = illegal_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit (honours CU_ILLEGAL_OP_EN).
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       memread, memtoreg, memwrite, regwrite;
  logic [1:0] store_control, load_control, aluop;
  logic       extend, lui_control, regdest, branch, alusrc;
  logic       jumpControl, jalControl, jrControl;
`ifdef CU_ILLEGAL_OP_EN
  logic       illegal_op;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .opcode        (opcode),
    .funct         (funct),
    .memread       (memread),
    .memtoreg      (memtoreg),
    .memwrite      (memwrite),
    .regwrite      (regwrite),
    .store_control (store_control),
    .extend        (extend),
    .lui_control   (lui_control),
    .load_control  (load_control),
    .regdest       (regdest),
    .branch        (branch),
    .alusrc        (alusrc),
    .aluop         (aluop),
    .jumpControl   (jumpControl),
    .jalControl    (jalControl),
`ifdef CU_ILLEGAL_OP_EN
    .illegal_op    (illegal_op),
`endif
    .jrControl     (jrControl)
  );

  // Field order: mr mt mw rw st[2] ex lui ld[2] rd br as aluop[2] j jal jr
  localparam logic [17:0] E_NOP  = 18'b0_0_0_0_00_0_0_00_0_0_0_00_0_0_0;
  localparam logic [17:0] E_LW   = 18'b1_1_0_1_00_1_0_00_0_0_1_00_0_0_0;
  localparam logic [17:0] E_LH   = 18'b1_1_0_1_00_1_0_01_0_0_1_00_0_0_0;
  localparam logic [17:0] E_LHU  = 18'b1_1_0_1_00_0_0_01_0_0_1_00_0_0_0;
  localparam logic [17:0] E_LB   = 18'b1_1_0_1_00_1_0_10_0_0_1_00_0_0_0;
  localparam logic [17:0] E_LBU  = 18'b1_1_0_1_00_0_0_10_0_0_1_00_0_0_0;
  localparam logic [17:0] E_SW   = 18'b0_0_1_0_00_1_0_00_0_0_1_00_0_0_0;
  localparam logic [17:0] E_SH   = 18'b0_0_1_0_01_1_0_00_0_0_1_00_0_0_0;
  localparam logic [17:0] E_SB   = 18'b0_0_1_0_10_1_0_00_0_0_1_00_0_0_0;
  localparam logic [17:0] E_LUI  = 18'b0_0_0_1_00_0_1_00_0_0_1_00_0_0_0;
  localparam logic [17:0] E_ADDI = 18'b0_0_0_1_00_1_0_00_0_0_1_00_0_0_0;
  localparam logic [17:0] E_BEQ  = 18'b0_0_0_0_00_1_0_00_0_1_0_01_0_0_0;
  localparam logic [17:0] E_J    = 18'b0_0_0_0_00_0_0_00_0_0_0_00_1_0_0;
  localparam logic [17:0] E_JAL  = 18'b0_0_0_1_00_0_0_00_0_0_0_00_1_1_0;
  localparam logic [17:0] E_RADD = 18'b0_0_0_1_00_0_0_00_1_0_0_10_0_0_0;
  localparam logic [17:0] E_JR   = 18'b0_0_0_0_00_0_0_00_0_0_0_10_0_0_1;

  function automatic logic [17:0] observed();
    return {memread, memtoreg, memwrite, regwrite, store_control, extend,
            lui_control, load_control, regdest, branch, alusrc, aluop,
            jumpControl, jalControl, jrControl};
  endfunction

  task automatic check(input string tag, input logic [17:0] exp, input logic exp_ill);
    logic [17:0] obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
`ifdef CU_ILLEGAL_OP_EN
    total++;
    assert (illegal_op === exp_ill) else begin
      bad++;
      $error("FAIL %s_illegal observed=%b expected=%b", tag, illegal_op, exp_ill);
    end
`else
    if (exp_ill === 1'bx) $display("unexpected");
`endif
  endtask

  // Present inputs away from the edge, then sample 1 time unit after posedge
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic stl);
    @(negedge clk);
    opcode = op;
    funct  = fn;
    stall  = stl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    opcode = 6'b100011;
    funct  = 6'b000000;
    #1;
    check("reset_init", E_NOP, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    step(6'b100011, 6'b000000, 1'b0);
    check("lw", E_LW, 1'b0);

    // Mid-cycle async reset clears outputs without a clock edge
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", E_NOP, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    step(6'b100011, 6'b000000, 1'b0); check("sweep_lw",   E_LW,   1'b0);
    step(6'b101011, 6'b000000, 1'b0); check("sweep_sw",   E_SW,   1'b0);
    // Latency: a new opcode must not show before the next edge
    @(negedge clk);
    opcode = 6'b100000;
    #1;
    check("latency_hold", E_SW, 1'b0);
    @(posedge clk); #1;
    check("sweep_lb",   E_LB,   1'b0);
    step(6'b100100, 6'b000000, 1'b0); check("sweep_lbu",  E_LBU,  1'b0);
    step(6'b100001, 6'b000000, 1'b0); check("sweep_lh",   E_LH,   1'b0);
    step(6'b100101, 6'b000000, 1'b0); check("sweep_lhu",  E_LHU,  1'b0);
    step(6'b001111, 6'b000000, 1'b0); check("sweep_lui",  E_LUI,  1'b0);
    step(6'b101000, 6'b000000, 1'b0); check("sweep_sb",   E_SB,   1'b0);
    step(6'b101001, 6'b000000, 1'b0); check("sweep_sh",   E_SH,   1'b0);
    step(6'b000000, 6'b100000, 1'b0); check("sweep_radd", E_RADD, 1'b0);
    step(6'b000000, 6'b001000, 1'b0); check("sweep_jr",   E_JR,   1'b0);
    step(6'b000010, 6'b000000, 1'b0); check("sweep_j",    E_J,    1'b0);
    step(6'b000011, 6'b000000, 1'b0); check("sweep_jal",  E_JAL,  1'b0);
    step(6'b001000, 6'b000000, 1'b0); check("sweep_addi", E_ADDI, 1'b0);
    step(6'b000100, 6'b000000, 1'b0); check("sweep_beq",  E_BEQ,  1'b0);
    // Non-R opcode with a jr-looking funct must ignore funct
    step(6'b101011, 6'b001000, 1'b0); check("sw_funct_ignored", E_SW, 1'b0);

    // Stall holds lw while opcode moves to sw
    step(6'b100011, 6'b000000, 1'b0); check("stall_pre_lw", E_LW, 1'b0);
    step(6'b101011, 6'b000000, 1'b1); check("stall_hold1",  E_LW, 1'b0);
    @(posedge clk); #1;
    check("stall_hold2", E_LW, 1'b0);
    step(6'b101011, 6'b000000, 1'b0); check("stall_release", E_SW, 1'b0);

    // Reset wins over stall
    @(negedge clk);
    stall = 1'b1;
    reset = 1'b1;
    #1;
    check("reset_over_stall", E_NOP, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;

    step(6'b111111, 6'b000000, 1'b0); check("illegal_111111", E_NOP, 1'b1);
    step(6'b100011, 6'b000000, 1'b0); check("legal_after_ill", E_LW, 1'b0);
    step(6'b010001, 6'b001000, 1'b0); check("illegal_010001", E_NOP, 1'b1);
    step(6'b000000, 6'b100010, 1'b0); check("rtype_sub", E_RADD, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
